// File: rtl/g15_pkg.sv
// rtl/g15_pkg.sv - word geometry and bit-counter type for the late-bus recomplement gate
package g15_pkg;

  localparam int WORD_BITS = 29;
  localparam int PAIR_BITS = 2 * WORD_BITS;
  localparam int SIGN_SLOT = 0;
  localparam int CNT_W     = $clog2(PAIR_BITS);

  typedef logic [CNT_W-1:0] bit_cnt_t;

  // Index of the final bit time of a word or pair; the two's-complement sign lives there.
  function automatic bit_cnt_t last_bit(input logic dp);
    return dp ? bit_cnt_t'(PAIR_BITS - 1) : bit_cnt_t'(WORD_BITS - 1);
  endfunction

endpackage

// File: rtl/serial_negator.sv
// rtl/serial_negator.sv - LSB-first serial two's-complement negate (copy through first 1, then invert)
module serial_negator (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic neg_i,
  input  logic d_i,
  output logic q_o
);

  logic seen_q;

  sr_ff u_seen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .set_i (d_i & ~clr_i),
    .clr_i (clr_i),
    .q_o   (seen_q)
  );

  assign q_o = (neg_i & seen_q) ? ~d_i : d_i;

endmodule

// File: rtl/sr_ff.sv
// rtl/sr_ff.sv - set/reset flag flop, set dominant, synchronous active-high reset
module sr_ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= 1'b0;
    end else if (set_i) begin
      q_q <= 1'b1;
    end else if (clr_i) begin
      q_q <= 1'b0;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/recomplement_gate_lb.sv
// rtl/recomplement_gate_lb.sv - serial two's-complement (late bus) to sign-magnitude, one word/pair delay
module recomplement_gate_lb
  import g15_pkg::*;
(
  input  logic CLOCK,
  input  logic rst,
  input  logic TS,
  input  logic T_ODD,
  input  logic DP,
  input  logic EN,
  input  logic LB,
  output logic SM,
  output logic SM_V,
  output logic OVFL
);

  logic [PAIR_BITS:0] sh_q, sh_d;
  bit_cnt_t           cap_cnt_q, cap_cnt_d;
  bit_cnt_t           em_cnt_q, em_cnt_d;
  logic               emit_go_q, emit_go_d;

  logic cap_act_q, cap_dp_q, em_act_q, em_dp_q, sign_q, any_one_q;
  logic cap_start, cap_last, em_last, dp_new, tap, mag_bit;

  assign dp_new    = DP & ~T_ODD;
  // An odd-word TS inside a pair capture is not a new word.
  assign cap_start = TS & EN & ~cap_act_q;
  assign cap_last  = cap_act_q & (cap_cnt_q == last_bit(cap_dp_q));
  assign em_last   = em_act_q & (em_cnt_q == last_bit(em_dp_q));

  sr_ff u_cap_act (.clk_i(CLOCK), .rst_i(rst), .set_i(cap_start),
                   .clr_i(cap_last), .q_o(cap_act_q));
  sr_ff u_cap_dp  (.clk_i(CLOCK), .rst_i(rst), .set_i(cap_start & dp_new),
                   .clr_i(cap_start & ~dp_new), .q_o(cap_dp_q));
  sr_ff u_em_act  (.clk_i(CLOCK), .rst_i(rst), .set_i(emit_go_q),
                   .clr_i(em_last), .q_o(em_act_q));
  sr_ff u_em_dp   (.clk_i(CLOCK), .rst_i(rst), .set_i(cap_last & cap_dp_q),
                   .clr_i(cap_last & ~cap_dp_q), .q_o(em_dp_q));
  sr_ff u_sign    (.clk_i(CLOCK), .rst_i(rst), .set_i(cap_last & LB),
                   .clr_i(cap_last & ~LB), .q_o(sign_q));
  // Any 1 among the magnitude bits; stays clear for the -2^(N-1) overflow case.
  sr_ff u_any_one (.clk_i(CLOCK), .rst_i(rst),
                   .set_i((cap_start | (cap_act_q & ~cap_last)) & LB),
                   .clr_i(cap_start), .q_o(any_one_q));

  always_comb begin
    sh_d      = {sh_q[PAIR_BITS-1:0], LB};
    emit_go_d = cap_last;
    cap_cnt_d = cap_cnt_q;
    em_cnt_d  = em_cnt_q;
    if (cap_start) begin
      cap_cnt_d = bit_cnt_t'(SIGN_SLOT + 1);
    end else if (cap_act_q) begin
      cap_cnt_d = cap_cnt_q + 1'b1;
    end
    if (emit_go_q) begin
      em_cnt_d = bit_cnt_t'(SIGN_SLOT + 1);
    end else if (em_act_q) begin
      em_cnt_d = em_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      sh_q      <= '0;
      cap_cnt_q <= '0;
      em_cnt_q  <= '0;
      emit_go_q <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      cap_cnt_q <= cap_cnt_d;
      em_cnt_q  <= em_cnt_d;
      emit_go_q <= emit_go_d;
    end
  end

  // Output bit k carries input bit k-1, which sits N+1 stages back in the delay line.
  assign tap = em_dp_q ? sh_q[PAIR_BITS] : sh_q[WORD_BITS];

  serial_negator u_neg (
    .clk_i (CLOCK),
    .rst_i (rst),
    .clr_i (emit_go_q),
    .neg_i (sign_q),
    .d_i   (tap),
    .q_o   (mag_bit)
  );

  assign SM_V = emit_go_q | em_act_q;
  assign SM   = emit_go_q ? sign_q : (em_act_q & mag_bit);
  assign OVFL = emit_go_q & sign_q & ~any_one_q;

endmodule

// File: tb/tb_recomplement_gate_lb.sv
// tb/tb_recomplement_gate_lb.sv - table, hand-sequence and random checks of recomplement_gate_lb
module tb_recomplement_gate_lb;
  import g15_pkg::*;

  logic CLOCK = 1'b0;
  logic rst, TS, T_ODD, DP, EN, LB;
  logic SM, SM_V, OVFL;

  recomplement_gate_lb dut (
    .CLOCK (CLOCK),
    .rst   (rst),
    .TS    (TS),
    .T_ODD (T_ODD),
    .DP    (DP),
    .EN    (EN),
    .LB    (LB),
    .SM    (SM),
    .SM_V  (SM_V),
    .OVFL  (OVFL)
  );

  always #5 CLOCK = ~CLOCK;

  localparam int MAXC = 8192;
  logic  exp_sm [MAXC];
  logic  exp_v  [MAXC];
  logic  exp_ov [MAXC];
  int    cyc;
  int    word_idx;
  bit    prev_dp_en;
  bit    chk_en;
  int    tests;
  int    fails;
  string phase;

  typedef struct {
    logic        en;
    logic        dp;
    logic [57:0] val;
    logic        es;
    logic [56:0] em;
    logic        eo;
  } vec_t;

  vec_t tbl [10];

  task automatic model(input int n, input logic [57:0] v,
                       output logic s, output logic [56:0] m, output logic o);
    logic [63:0] x, full, half;
    full = 64'd1 << n;
    half = 64'd1 << (n - 1);
    x    = {6'd0, v} & (full - 64'd1);
    s = 1'b0; m = '0; o = 1'b0;
    if (x >= half) begin
      s = 1'b1;
      x = full - x;
      if (x == half) o = 1'b1;
      else           m = x[56:0];
    end else begin
      m = x[56:0];
    end
  endtask

  task automatic step(input logic ts, input logic todd, input logic dp,
                      input logic en, input logic lb, input logic r);
    TS = ts; T_ODD = todd; DP = dp; EN = en; LB = lb; rst = r;
    if (r) begin
      for (int c = cyc + 1; c < MAXC; c++) begin
        exp_sm[c] = 1'b0; exp_v[c] = 1'b0; exp_ov[c] = 1'b0;
      end
    end
    @(negedge CLOCK);
    if (chk_en) begin
      tests++;
      if (SM !== exp_sm[cyc] || SM_V !== exp_v[cyc] || OVFL !== exp_ov[cyc]) begin
        fails++;
        $display("FAIL %s cyc=%0d SM/SM_V/OVFL got %b%b%b want %b%b%b", phase, cyc,
                 SM, SM_V, OVFL, exp_sm[cyc], exp_v[cyc], exp_ov[cyc]);
      end
    end
    @(posedge CLOCK); #1;
    cyc++;
  endtask

  task automatic idle_word();
    for (int i = 0; i < WORD_BITS; i++)
      step(i == 0, word_idx[0], 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    word_idx++;
    prev_dp_en = 1'b0;
  endtask

  task automatic send(input logic en, input logic dp, input logic [57:0] val,
                      input bit tab, input logic es, input logic [56:0] em,
                      input logic eo, input int rst_at);
    int n, st;
    logic s, o, todd, dpi, eni;
    logic [56:0] m;
    if (dp && word_idx[0]) idle_word();
    if (en && !dp && prev_dp_en) idle_word();
    n  = dp ? PAIR_BITS : WORD_BITS;
    st = cyc;
    if (en) begin
      if (tab) begin s = es; m = em; o = eo; end
      else model(n, val, s, m, o);
      for (int k = 0; k < n; k++) begin
        if (st + n + k < MAXC) begin
          exp_v[st + n + k]  = 1'b1;
          exp_sm[st + n + k] = (k == 0) ? s : m[k - 1];
          exp_ov[st + n + k] = (k == 0) ? o : 1'b0;
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      todd = 1'((word_idx + i / WORD_BITS) % 2);
      dpi  = (i < WORD_BITS) ? dp : 1'b0;
      eni  = (i < WORD_BITS) ? en : (dp & en);
      step((i % WORD_BITS) == 0, todd, dpi, eni, val[i], i == rst_at);
    end
    word_idx  += n / WORD_BITS;
    prev_dp_en = en && dp && (rst_at < 0);
  endtask

  initial begin
    logic        en_r, dp_r;
    logic [57:0] v;
    int          n, sel;

    tests = 0; fails = 0; cyc = 0; word_idx = 0; prev_dp_en = 1'b0; chk_en = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      exp_sm[c] = 1'b0; exp_v[c] = 1'b0; exp_ov[c] = 1'b0;
    end

    tbl[0] = '{1'b1, 1'b0, 58'd5,                 1'b0, 57'd5,         1'b0};
    tbl[1] = '{1'b1, 1'b0, 58'h1FFFFFFB,          1'b1, 57'd5,         1'b0};
    tbl[2] = '{1'b1, 1'b0, 58'h10000000,          1'b1, 57'd0,         1'b1};
    tbl[3] = '{1'b1, 1'b0, 58'd1,                 1'b0, 57'd1,         1'b0};
    tbl[4] = '{1'b1, 1'b0, 58'h1FFFFFFF,          1'b1, 57'd1,         1'b0};
    tbl[5] = '{1'b1, 1'b0, 58'd0,                 1'b0, 57'd0,         1'b0};
    tbl[6] = '{1'b1, 1'b0, 58'h18000000,          1'b1, 57'h8000000,   1'b0};
    tbl[7] = '{1'b1, 1'b1, 58'h3FFFFFFFFFFFFFD,   1'b1, 57'd3,         1'b0};
    tbl[8] = '{1'b1, 1'b1, 58'h200000000000000,   1'b1, 57'd0,         1'b1};
    tbl[9] = '{1'b0, 1'b1, 58'h155555555555555,   1'b0, 57'd0,         1'b0};

    phase = "reset";
    TS = 1'b0; T_ODD = 1'b0; DP = 1'b0; EN = 1'b0; LB = 1'b0; rst = 1'b1;
    @(posedge CLOCK); #1;
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    phase = "table";
    for (int i = 0; i < 10; i++)
      send(tbl[i].en, tbl[i].dp, tbl[i].val, 1'b1, tbl[i].es, tbl[i].em, tbl[i].eo, -1);
    idle_word();
    idle_word();

    phase = "rst_mid";
    send(1'b1, 1'b0, 58'd5, 1'b1, 1'b0, 57'd5, 1'b0, -1);
    send(1'b1, 1'b0, 58'h1FFFFFFB, 1'b1, 1'b1, 57'd5, 1'b0, 14);
    send(1'b1, 1'b0, 58'h1FFFFFFB, 1'b1, 1'b1, 57'd5, 1'b0, -1);
    send(1'b0, 1'b0, 58'h0ABCDEF, 1'b1, 1'b0, 57'd0, 1'b0, 14);
    send(1'b1, 1'b0, 58'd7, 1'b1, 1'b0, 57'd7, 1'b0, -1);
    idle_word();

    phase = "random";
    for (int i = 0; i < 40; i++) begin
      en_r = ($urandom_range(0, 9) < 8);
      dp_r = ($urandom_range(0, 3) == 0);
      n    = dp_r ? PAIR_BITS : WORD_BITS;
      sel  = $urandom_range(0, 7);
      case (sel)
        0:       v = '0;
        1:       v = 58'd1 << (n - 1);
        2:       v = '1;
        3:       v = (58'd1 << (n - 1)) - 58'd1;
        default: v = {$urandom, $urandom};
      endcase
      send(en_r, dp_r, v, 1'b0, 1'b0, 57'd0, 1'b0, -1);
    end

    phase = "flush";
    for (int i = 0; i < 4; i++) idle_word();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
